// File: rtl/hsv_core_fetch_pkg.sv
// rtl/hsv_core_fetch_pkg.sv - shared AXI constants and fetch record type for hsv_core_fetch
package hsv_core_fetch_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
   localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
   localparam logic [2:0] AXI_SIZE_4     = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic [31:0] pc_increment;
      logic        fault;
   } fetch_data_t;

endpackage

// File: rtl/hsv_core_fetch.sv
// rtl/hsv_core_fetch.sv - single-outstanding AXI instruction fetch unit with flush/discard handling
module hsv_core_fetch
   import hsv_core_fetch_pkg::*;
#(
   parameter logic [31:0] ResetPc = 32'h0000_0000
) (
   input  logic        clk_core,
   input  logic        rst_core_n,
   input  logic        flush_req,
   input  logic [31:0] flush_target,
   output logic        ar_valid,
   input  logic        ar_ready,
   output logic [31:0] ar_addr,
   output logic [7:0]  ar_len,
   output logic [2:0]  ar_size,
   output logic [1:0]  ar_burst,
   input  logic        r_valid,
   output logic        r_ready,
   input  logic [31:0] r_data,
   input  axi_resp_t   r_resp,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output fetch_data_t fetch_data
);

   localparam logic [2:0] REQUEST = 3'd0;
   localparam logic [2:0] WAIT_R  = 3'd1;
   localparam logic [2:0] HOLD    = 3'd2;
   localparam logic [2:0] DISCARD = 3'd3;
   localparam logic [2:0] STALL   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ar_valid_q, ar_valid_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   fetch_data_t fetch_data_q, fetch_data_d;

   logic        ar_hs;
   logic        pc_q_is_mem;
   logic        pc_d_is_mem;
   logic        unused_resp_lsb;

   assign ar_hs       = ar_valid_q && ar_ready;
   assign pc_q_is_mem = (pc_q[1:0] == 2'b00) && (pc_q[31:30] == 2'b00);
   assign pc_d_is_mem = (pc_d[1:0] == 2'b00) && (pc_d[31:30] == 2'b00);

   // Only the error bit of the response matters; OKAY and EXOKAY are both success.
   assign unused_resp_lsb = r_resp[0];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_data_d = fetch_data_q;

      case (state_q)
         REQUEST: begin
            if (flush_req) begin
               pc_d    = flush_target;
               state_d = ar_valid_q ? DISCARD : REQUEST;
            end else if (!pc_q_is_mem) begin
               fetch_data_d.insn         = 32'h0000_0000;
               fetch_data_d.pc           = pc_q;
               fetch_data_d.pc_increment = pc_q + 32'd4;
               fetch_data_d.fault        = 1'b1;
               state_d                   = HOLD;
            end else if (ar_hs) begin
               state_d = WAIT_R;
            end
         end
         WAIT_R: begin
            // A beat taken in the same cycle as the flush leaves nothing to discard.
            if (flush_req) begin
               pc_d    = flush_target;
               state_d = r_valid ? REQUEST : DISCARD;
            end else if (r_valid) begin
               fetch_data_d.insn         = r_data;
               fetch_data_d.pc           = pc_q;
               fetch_data_d.pc_increment = pc_q + 32'd4;
               fetch_data_d.fault        = r_resp[1];
               state_d                   = HOLD;
            end
         end
         HOLD: begin
            if (flush_req) begin
               pc_d    = flush_target;
               state_d = REQUEST;
            end else if (fetch_ready) begin
               if (fetch_data_q.fault) begin
                  state_d = STALL;
               end else begin
                  pc_d    = pc_q + 32'd4;
                  state_d = REQUEST;
               end
            end
         end
         DISCARD: begin
            if (flush_req) begin
               pc_d = flush_target;
            end
            if (r_valid) begin
               state_d = REQUEST;
            end
         end
         STALL: begin
            if (flush_req) begin
               pc_d    = flush_target;
               state_d = REQUEST;
            end
         end
         default: begin
            state_d = REQUEST;
         end
      endcase

      // An offered address is never withdrawn or changed before it is accepted.
      if (ar_valid_q && !ar_ready) begin
         ar_valid_d = 1'b1;
         ar_addr_d  = ar_addr_q;
      end else begin
         ar_valid_d = (state_d == REQUEST) && pc_d_is_mem;
         ar_addr_d  = pc_d;
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q      <= REQUEST;
         pc_q         <= ResetPc;
         ar_valid_q   <= 1'b0;
         ar_addr_q    <= ResetPc;
         fetch_data_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ar_valid_q   <= ar_valid_d;
         ar_addr_q    <= ar_addr_d;
         fetch_data_q <= fetch_data_d;
      end
   end

   assign ar_valid    = ar_valid_q;
   assign ar_addr     = ar_addr_q;
   assign ar_len      = 8'h00;
   assign ar_size     = AXI_SIZE_4;
   assign ar_burst    = AXI_BURST_INCR;
   assign r_ready     = (state_q == WAIT_R) || (state_q == DISCARD);
   assign fetch_valid = (state_q == HOLD);
   assign fetch_data  = fetch_data_q;

endmodule

// File: doc/hsv_core_fetch.md
HSV_CORE_FETCH -- requirements
Module: hsv_core_fetch

Interface
REQ-001 SHALL have parameter ResetPc, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk_core, input, 1 bit: single core clock; all state updates on rising edge.
REQ-003 SHALL have port rst_core_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port flush_req, input, 1 bit: redirect request from commit.
REQ-005 SHALL have port flush_target, input, 32 bits: new fetch PC, sampled when flush_req=1.
REQ-006 SHALL have port ar_valid, output, 1 bit: AXI read address valid.
REQ-007 SHALL have port ar_ready, input, 1 bit: AXI read address ready.
REQ-008 SHALL have port ar_addr, output, 32 bits: fetch address.
REQ-009 SHALL have ports ar_len, ar_size and ar_burst as outputs of 8, 3 and 2 bits, tied to 0, AXI_SIZE_4 and AXI_BURST_INCR.
REQ-010 SHALL have port r_valid, input, 1 bit; r_ready, output, 1 bit; r_data, input, 32 bits; r_resp, input, 2 bits (axi_resp_t).
REQ-011 SHALL have port fetch_valid, output, 1 bit; fetch_ready, input, 1 bit; fetch_data, output, fetch_data_t (insn, pc, pc_increment, fault).

Function
REQ-012 SHALL implement states REQUEST, WAIT_R, HOLD, DISCARD and STALL; at most one AXI read outstanding.
REQ-013 REQUEST: if PC is misaligned (pc[1:0]!=0) or PC is not memory (pc[31:30]!=0), SHALL issue no AR and SHALL load output {insn=0, pc, pc+4, fault=1}, then go to HOLD next cycle.
REQ-014 REQUEST, legal PC: SHALL drive ar_valid=1 and ar_addr=pc; SHALL move to WAIT_R on the ar_valid&&ar_ready cycle.
REQ-015 Once asserted, ar_valid and ar_addr SHALL stay stable until ar_ready, flush included (AXI rule).
REQ-016 WAIT_R and DISCARD SHALL drive r_ready=1; r_ready SHALL be 0 in all other states.
REQ-017 WAIT_R, on r handshake: SHALL register {insn=r_data, pc, pc_increment=pc+4, fault=r_resp[1]} and go to HOLD; fetch_valid SHALL be 1 in the following cycle.
REQ-018 HOLD: fetch_valid=1 and fetch_data SHALL stay stable until fetch_ready.
REQ-019 HOLD, on handshake with fault=0: PC SHALL advance by 4 (mod 2^32 wrap) and the FSM SHALL go to REQUEST.
REQ-020 HOLD, on handshake with fault=1: the FSM SHALL go to STALL; it SHALL issue no requests until a flush.
REQ-021 flush_req SHALL have top priority in every state; PC SHALL load flush_target and fetch_valid SHALL be 0 from the next cycle on.
REQ-022 A flush in HOLD SHALL drop the held entry, including when it coincides with a fetch_ready handshake.
REQ-023 A flush in WAIT_R, or in REQUEST with an AR accepted or pending, SHALL go to DISCARD. DISCARD SHALL consume and drop exactly one R beat, then go to REQUEST.
REQ-024 A flush while already in DISCARD SHALL update the PC but SHALL still drop only the single outstanding beat.
REQ-025 fetch_valid SHALL be 0 in every state other than HOLD.
REQ-026 Minimum latency SHALL be: AR at cycle N, R at N+1, fetch_valid at N+2, next AR at N+3 when fetch_ready=1.

Reset
REQ-027 While rst_core_n=0, outputs SHALL be ar_valid=0, r_ready=0, fetch_valid=0, fetch_data=0, PC=ResetPc, state=REQUEST.
REQ-028 ar_valid SHALL first assert on the first rising edge after reset deasserts.
REQ-029 A reset asserted mid-transaction SHALL abandon that transaction immediately, with no DISCARD.

Verification
REQ-030 Scenario, sequential fetch: ResetPc=0, ar_ready=1, r_valid one cycle after AR, r_data=32'h00000013, fetch_ready=1 -> ar_addr 0x0, 0x4, 0x8 with fetch_data.pc/pc_increment 0/4, 4/8, 8/C, fault=0.
REQ-031 Scenario, backpressure: fetch_ready=0 for 5 cycles in HOLD -> fetch_data stable, ar_valid=0 throughout, single accept on release.
REQ-032 Scenario, in-flight flush: flush_req with flush_target=0x100 while in WAIT_R -> stale R beat dropped (no fetch_valid), next ar_addr=0x100.
REQ-033 Scenario, AR stall plus flush: ar_ready=0, flush to 0x200 -> ar_addr held at old PC until accepted, old beat discarded, then ar_addr=0x200.
REQ-034 Scenario, faults: flush to 0x4000_0000 -> no AR, fetch_data {insn=0, pc=0x4000_0000, fault=1}, then STALL. Flush to 0x10 with r_resp=SLVERR -> fault=1, then STALL until next flush.
REQ-035 Scenario, wrap and reset: PC=0xFFFF_FFFC with fault=1 case excluded via pc[31:30] check (no wrap to 0 fetch); asserting rst_core_n=0 mid-WAIT_R -> next ar_addr=ResetPc with no DISCARD.
